// File: rtl/aes_pkg.sv
// Shared AES constants: forward S-box, key-expansion round constants, FSM encodings.
package aes_pkg;

    localparam int NR = 14;
    localparam int NK = 8;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Rcon[1..7]; index 0 holds Rcon[1].
    localparam logic [0:6][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

endpackage

// File: rtl/aes_sub_word.sv
// Byte-wise S-box substitution of one 32-bit word (purely combinational).
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                       SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};

endmodule

// File: rtl/aes256_key_sched.sv
// AES-256 key schedule: expands one round key per cycle into a 15-entry buffer,
// then streams the keys forward (encrypt) or in reverse (decrypt) on request.
module aes256_key_sched #(
    parameter int NR = 14,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [255:0]  key_in,
    input  logic          key_load,
    input  logic          start,
    input  logic          enc_en,
    input  logic          key_next,
    output logic [KW-1:0] round_key,
    output logic          key_valid,
    output logic          last_key,
    output logic          key_ready
);
    import aes_pkg::*;

    logic [1:0]    state_q, state_d;
    logic [3:0]    n_q, n_d;
    logic [3:0]    ptr_q, ptr_d;
    logic          dir_q, dir_d;
    logic [KW-1:0] round_key_q, round_key_d;
    logic          key_valid_q, key_valid_d;
    logic          last_key_q, last_key_d;
    logic          key_ready_q, key_ready_d;

    logic [KW-1:0] rk_q [0:NR];
    logic          rk_we;

    logic [KW-1:0] p_rk, prev_rk, rk_new;
    logic [31:0]   t_word, sub_in, sub_out, rcon_word, temp;
    logic [31:0]   w0, w1, w2, w3;

    // Even steps rotate and add Rcon; odd steps substitute only (the AES-256 Nk=8 rule).
    assign p_rk      = rk_q[n_q - 4'd2];
    assign prev_rk   = rk_q[n_q - 4'd1];
    assign t_word    = prev_rk[31:0];
    assign sub_in    = n_q[0] ? t_word : {t_word[23:0], t_word[31:24]};
    assign rcon_word = n_q[0] ? 32'h0 : {RCON[n_q[3:1] - 3'd1], 24'h0};
    assign temp      = sub_out ^ rcon_word;
    assign w0        = p_rk[127:96] ^ temp;
    assign w1        = p_rk[95:64]  ^ w0;
    assign w2        = p_rk[63:32]  ^ w1;
    assign w3        = p_rk[31:0]   ^ w2;
    assign rk_new    = {w0, w1, w2, w3};

    aes_sub_word u_sub_word (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    always_comb begin
        // NOTE: every signal gets a default up front so no path leaves it unassigned (no latches).
        state_d     = state_q;
        n_d         = n_q;
        ptr_d       = ptr_q;
        dir_d       = dir_q;
        round_key_d = round_key_q;
        key_valid_d = key_valid_q;
        last_key_d  = last_key_q;
        key_ready_d = key_ready_q;
        rk_we       = 1'b0;

        if (key_load) begin
            state_d     = ST_EXPAND;
            n_d         = 4'd2;
            round_key_d = '0;
            key_valid_d = 1'b0;
            last_key_d  = 1'b0;
            key_ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_EXPAND: begin
                    rk_we = 1'b1;
                    n_d   = n_q + 4'd1;
                    if (n_q == 4'(NR)) begin
                        state_d     = ST_READY;
                        key_ready_d = 1'b1;
                    end
                end
                ST_READY: begin
                    if (start) begin
                        dir_d       = enc_en;
                        ptr_d       = enc_en ? 4'd0 : 4'(NR);
                        round_key_d = rk_q[ptr_d];
                        key_valid_d = 1'b1;
                        last_key_d  = 1'b0;
                    end else if (key_next && key_valid_q) begin
                        if (last_key_q) begin
                            round_key_d = '0;
                            key_valid_d = 1'b0;
                            last_key_d  = 1'b0;
                        end else begin
                            ptr_d       = dir_q ? ptr_q + 4'd1 : ptr_q - 4'd1;
                            round_key_d = rk_q[ptr_d];
                            last_key_d  = (ptr_d == (dir_q ? 4'(NR) : 4'd0));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            ptr_q       <= '0;
            dir_q       <= 1'b0;
            round_key_q <= '0;
            key_valid_q <= 1'b0;
            last_key_q  <= 1'b0;
            key_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            ptr_q       <= ptr_d;
            dir_q       <= dir_d;
            round_key_q <= round_key_d;
            key_valid_q <= key_valid_d;
            last_key_q  <= last_key_d;
            key_ready_q <= key_ready_d;
        end
    end

    // NOTE: the key buffer has no reset; key_ready gates its use, so stale contents are never exposed.
    always_ff @(posedge clk) begin
        if (key_load) begin
            rk_q[0] <= key_in[255:128];
            rk_q[1] <= key_in[127:0];
        end else if (rk_we) begin
            rk_q[n_q] <= rk_new;
        end
    end

    assign round_key = round_key_q;
    assign key_valid = key_valid_q;
    assign last_key  = last_key_q;
    assign key_ready = key_ready_q;

endmodule

// File: tb/tb_aes256_key_sched.sv
// Self-checking bench for aes256_key_sched: known vectors, a word-level FIPS-197
// expansion model (S-box derived from GF(2^8) inverses), and multi-cycle corner cases.
module tb_aes256_key_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] key_in = '0;
    logic         key_load = 1'b0;
    logic         start = 1'b0;
    logic         enc_en = 1'b0;
    logic         key_next = 1'b0;
    logic [127:0] round_key;
    logic         key_valid;
    logic         last_key;
    logic         key_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] model_rk [15];
    logic [127:0] got_rk [15];

    typedef struct {
        int           idx;
        logic [127:0] rk;
    } vec_t;

    vec_t vecs [4];

    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes256_key_sched #(.NR(14), .KW(128)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_load  (key_load),
        .start     (start),
        .enc_en    (enc_en),
        .key_next  (key_next),
        .round_key (round_key),
        .key_valid (key_valid),
        .last_key  (last_key),
        .key_ready (key_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        logic [15:0] d;
        d = {v, v};
        return d[15-k -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // Standard FIPS-197 word loop over w[0..59].
    task automatic model_expand(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_round_key"}, round_key, '0);
        check({tag, "_key_valid"}, 128'(key_valid), 128'd0);
        check({tag, "_last_key"},  128'(last_key), 128'd0);
        check({tag, "_key_ready"}, 128'(key_ready), 128'd0);
    endtask

    task automatic pulse_load(input logic [255:0] k);
        key_in   = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        model_expand(k);
    endtask

    // Counts edges from the load edge until key_ready; expects exactly 13.
    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (!key_ready && cnt < 40) begin
            step();
            cnt++;
        end
        check({tag, "_latency"}, 128'(cnt), 128'd13);
    endtask

    task automatic run_session(input bit enc, input int gap_max, input int hold_at);
        int idx;
        int ngap;
        enc_en = enc;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int k = 0; k < 15; k++) begin
            idx = enc ? k : 14 - k;
            check("sess_key", round_key, model_rk[idx]);
            check("sess_valid", 128'(key_valid), 128'd1);
            check("sess_last", 128'(last_key), 128'(k == 14));
            got_rk[idx] = round_key;
            ngap = (k == hold_at) ? 5 : int'($urandom_range(0, gap_max));
            for (int g = 0; g < ngap; g++) begin
                step();
                check("hold_key", round_key, model_rk[idx]);
                check("hold_valid", 128'(key_valid), 128'd1);
            end
            key_next = 1'b1;
            step();
            key_next = 1'b0;
        end
        check("end_valid", 128'(key_valid), 128'd0);
        check("end_last", 128'(last_key), 128'd0);
        check("end_round_key", round_key, '0);
        check("end_ready", 128'(key_ready), 128'd1);
        step();
        check("post_end_valid", 128'(key_valid), 128'd0);
    endtask

    initial begin
        vecs[0] = '{0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{1,  128'h101112131415161718191a1b1c1d1e1f};
        vecs[2] = '{2,  128'ha573c29fa176c498a97fce93a572c09c};
        vecs[3] = '{14, 128'h24fc79ccbf0979e9371ac23c6d68de36};

        build_sbox();

        #12;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        step();

        // start before any key is loaded is ignored
        enc_en = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        check("start_no_key_valid", 128'(key_valid), 128'd0);

        // Known expansion vector, forward then reverse
        pulse_load(FIPS_KEY);
        check("load_ready_low", 128'(key_ready), 128'd0);
        wait_ready("fips");
        run_session(1'b1, 0, 5);
        for (int i = 0; i < 4; i++) check("vec_fwd", got_rk[vecs[i].idx], vecs[i].rk);
        run_session(1'b0, 1, -1);
        for (int i = 0; i < 4; i++) check("vec_rev", got_rk[vecs[i].idx], vecs[i].rk);

        // Restart mid-session; start wins over a simultaneous key_next
        enc_en = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        key_next = 1'b1;
        step();
        step();
        key_next = 1'b0;
        check("advance_two", round_key, vecs[2].rk);
        enc_en   = 1'b0;
        start    = 1'b1;
        key_next = 1'b1;
        step();
        start    = 1'b0;
        key_next = 1'b0;
        check("restart_key", round_key, vecs[3].rk);
        check("restart_last", 128'(last_key), 128'd0);
        check("restart_valid", 128'(key_valid), 128'd1);
        run_session(1'b1, 1, -1);

        // Abort: reload at cycle 6 of EXPAND, start during EXPAND ignored
        pulse_load({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        repeat (4) step();
        enc_en = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        check("start_in_expand_valid", 128'(key_valid), 128'd0);
        pulse_load({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        check("abort_ready_low", 128'(key_ready), 128'd0);
        wait_ready("abort");
        run_session(1'b1, 1, -1);

        // key_load mid-session aborts it
        enc_en = 1'b0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        key_next = 1'b1;
        step();
        key_next = 1'b0;
        pulse_load(FIPS_KEY);
        check("load_in_session_valid", 128'(key_valid), 128'd0);
        check("load_in_session_ready", 128'(key_ready), 128'd0);
        wait_ready("reload");
        run_session(1'b0, 0, 7);

        // Random keys and directions
        for (int r = 0; r < 4; r++) begin
            pulse_load({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            wait_ready("rand");
            run_session(1'($urandom_range(0, 1)), 2, -1);
        end

        // Async reset between edges mid-session
        enc_en = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        key_next = 1'b1;
        step();
        key_next = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        #2;
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("post_rst_start_valid", 128'(key_valid), 128'd0);
        check("post_rst_ready", 128'(key_ready), 128'd0);
        pulse_load(FIPS_KEY);
        wait_ready("post_rst");
        run_session(1'b1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes256_key_sched.md
Name: aes256_key_sched

Overview:
- Round-key producer for the iterative AES-256 datapath; feeds the per-round `key` input of the encrypt/decrypt round.
- Expands a 256-bit cipher key into the 15 round keys (rk0..rk14) and holds them in an internal buffer.
- Streams the keys one per request: forward order for encryption, reverse order for decryption.
- Raw (non-InvMixColumns) keys are delivered in both directions; the round applies its own inverse ordering.

Parameters:
- NR, 14, number of rounds; round-key count is NR+1. Only 14 is supported.
- KW, 128, round-key width in bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- key_in  in  256  cipher key; w0 = key_in[255:224], big-endian word order as FIPS-197
- key_load  in  1  one-cycle pulse; samples key_in and starts expansion
- start  in  1  one-cycle pulse; begins a delivery session
- enc_en  in  1  sampled with start: 1 = encrypt (forward), 0 = decrypt (reverse)
- key_next  in  1  consumer accepted current round_key; advance
- round_key  out  128  current round key (registered)
- key_valid  out  1  round_key is valid for the active session
- last_key  out  1  round_key is the final key of the session (drives the round's final-round enable)
- key_ready  out  1  all 15 round keys are expanded and stored

Behaviour:
- Clock and reset: one clock, asynchronous active-low reset rst_n.
- Reset values: round_key=0, key_valid=0, last_key=0, key_ready=0, FSM=IDLE, pointers=0. The key buffer is not reset.
- FSM states: IDLE, EXPAND, READY. Delivery is a sub-state of READY, tracked by key_valid.
- key_load sampled high (any state, including mid-EXPAND or mid-session):
  - rk0 <= key_in[255:128]; rk1 <= key_in[127:0]; n <= 2.
  - key_ready <= 0, key_valid <= 0, last_key <= 0; go to EXPAND.
  - Any earlier expansion or session is aborted.
- EXPAND: computes one round key per cycle.
  - Inputs: p = rk[n-2], t = last word of rk[n-1].
  - n even: temp = SubWord(RotWord(t)) ^ {Rcon[n/2],24'h0}. Rcon = 01,02,04,08,10,20,40 for n = 2..14.
  - n odd: temp = SubWord(t).
  - Output words: w0 = p.w0^temp; w1 = p.w1^w0; w2 = p.w2^w1; w3 = p.w3^w2.
  - rk[n] written; n increments. After rk14 is written, go to READY and set key_ready <= 1.
- Latency: key_load at edge E0 → rk2 written at E1 … rk14 written at E13 → key_ready=1 after E13 (13 cycles of EXPAND).
- start:
  - Ignored unless state=READY.
  - In READY, latch dir = enc_en; ptr <= 0 (enc) or 14 (dec).
  - Next cycle: round_key = rk[ptr], key_valid = 1, last_key = 0.
  - start during an active session restarts it from the first key.
- key_next with key_valid=1 and last_key=0: ptr steps +1 (enc) or −1 (dec); round_key updates the next cycle.
  - last_key = 1 when the new ptr is 14 (enc) or 0 (dec).
- key_next with last_key=1: session ends next cycle. key_valid=0, last_key=0, round_key=0, key_ready stays 1.
- key_next with key_valid=0 is ignored.
- Simultaneous events:
  - key_load has priority over start and key_next.
  - start has priority over key_next.
- Keys persist: multiple sessions may run after one key_load, in either direction.
- Reset asserted mid-operation returns all outputs to reset values immediately. No partial key is exposed afterwards, because key_ready=0.

Decomposition:
- Shared package aes_pkg: the 256-entry S-box constant table, the Rcon table (7 entries), and constants NR=14 and NK=8.
- Sub-module aes_sub_word: 32-bit combinational S-box substitution of 4 bytes, using the package table. One instance, shared by both the even and odd steps.
- Everything else is inline: FSM, 15x128 key buffer, expansion counter n, delivery pointer ptr.

Test Plan:
- Expansion vector: key_in = 000102…1e1f, pulse key_load → key_ready rises exactly 13 cycles later. Then start with enc_en=1 → first round_key = 000102030405060708090a0b0c0d0e0f.
- Forward session: same key, enc_en=1, key_next each cycle:
  - 3rd key = a573c29fa176c498a97fce93a572c09c.
  - 15th key = 24fc79ccbf0979e9371ac23c6d68de36 with last_key=1.
  - One more key_next → key_valid=0.
- Reverse session: start with enc_en=0 → first key = 24fc79cc…6d68de36; 15th key = 00010203…0e0f with last_key=1.
- Backpressure: hold key_next=0 for 5 cycles mid-session → round_key and key_valid are stable; no key is skipped or repeated.
- Abort: key_load mid-EXPAND (cycle 6) with a new key → key_ready=0; it rises 13 cycles after the second load, and keys match the second key's FIPS expansion.
  - Also: start while key_ready=0 → no key_valid.
- Async reset: deassert rst_n mid-session between clock edges → all outputs are 0 immediately. After release, start is ignored until a new key_load completes.
